// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// Bounded bursts, valid/ready handshakes and a registered write strobe/mux select.
module wb_port_arbiter #(
    parameter int unsigned AW        = 3,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter bit          DROP_ZERO = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [DW-1:0] i_req0_data,
    input  logic          i_req1_valid,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [DW-1:0] i_req1_data,
    output logic          o_req0_ready,
    output logic          o_req1_ready,
    input  logic          i_wr_stall,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_sel
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e        r_state;
    logic   [3:0]  r_cnt;
    logic          r_last;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_sel;

    state_e        w_state_nxt;
    logic   [3:0]  w_cnt_nxt;
    logic          w_last_nxt;
    logic          w_own_vld;
    logic          w_owner;
    logic          w_xfer;
    logic          w_same;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_wr_en_nxt;

    // Owner for this cycle; only a valid requester can ever be chosen.
    always_comb begin
        w_own_vld = 1'b0;
        w_owner   = 1'b0;
        case (r_state)
            StOwn0: begin
                if (i_req0_valid && (r_cnt < MaxBurst || !i_req1_valid)) begin
                    w_own_vld = 1'b1;
                    w_owner   = 1'b0;
                end else if (i_req1_valid) begin
                    w_own_vld = 1'b1;
                    w_owner   = 1'b1;
                end
            end
            StOwn1: begin
                if (i_req1_valid && (r_cnt < MaxBurst || !i_req0_valid)) begin
                    w_own_vld = 1'b1;
                    w_owner   = 1'b1;
                end else if (i_req0_valid) begin
                    w_own_vld = 1'b1;
                    w_owner   = 1'b0;
                end
            end
            default: begin
                if (i_req0_valid && i_req1_valid) begin
                    w_own_vld = 1'b1;
                    w_owner   = ~r_last;
                end else if (i_req0_valid) begin
                    w_own_vld = 1'b1;
                    w_owner   = 1'b0;
                end else if (i_req1_valid) begin
                    w_own_vld = 1'b1;
                    w_owner   = 1'b1;
                end
            end
        endcase
    end

    assign w_xfer       = w_own_vld & ~i_wr_stall & ~i_rst;
    assign o_req0_ready = w_xfer & ~w_owner;
    assign o_req1_ready = w_xfer & w_owner;

    assign w_same = ((r_state == StOwn0) && !w_owner) || ((r_state == StOwn1) && w_owner);
    assign w_addr = w_owner ? i_req1_addr : i_req0_addr;
    assign w_data = w_owner ? i_req1_data : i_req0_data;
    assign w_wr_en_nxt = w_xfer & ~(DROP_ZERO && (w_addr == '0));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        if (w_xfer) begin
            w_state_nxt = w_owner ? StOwn1 : StOwn0;
            w_last_nxt  = w_owner;
            if (w_same) begin
                w_cnt_nxt = (r_cnt == MaxBurst) ? r_cnt : r_cnt + 4'd1;
            end else begin
                w_cnt_nxt = 4'd1;
            end
        end else if (!i_wr_stall && !w_own_vld) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 4'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= 4'd0;
            r_last    <= 1'b1;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_sel     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_wr_en <= w_wr_en_nxt;
            if (w_xfer) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
                r_sel     <= w_owner;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_sel     = r_sel;

endmodule
